// File: rtl/serial_frame_deserializer.sv
// Serial frame deserializer: receives start(1) + DATA_W data bits LSB-first
// + optional even parity + stop(0), one bit per clk, and presents the word on
// a valid/ready interface with parity/frame error flags.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   q_in                serial line (idle 0, start 1, stop 0)
//   data_out            received word, stable while data_valid
//   data_valid          word available, held until accepted
//   data_ready          consumer accept strobe
//   parity_err          parity mismatch for the held word
//   frame_err           stop bit of the held word sampled as 1
//   overrun             one-cycle pulse when a completed frame is dropped
//   busy                receiver FSM not idle (combinational)
module serial_frame_deserializer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              q_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              frame_done;
  logic [DATA_W-1:0] sreg;
  logic              par_bit;
  logic              perr_calc;

  // State and bit counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; frame_done marks the stop-bit sampling cycle
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (q_in) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
        end
      end
      DATA: begin
        if (cnt == CW'(DATA_W - 1)) begin
          state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PARITY: state_nxt = STOP;
      STOP: begin
        // A stop bit of 1 is an error, never a new start bit
        state_nxt  = IDLE;
        frame_done = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  assign perr_calc = (PARITY_EN != 0) && ((^sreg) != par_bit);

  // Shift register (LSB first: each new bit enters at the top and moves down)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      par_bit <= 1'b0;
    end else begin
      if (state == DATA) begin
        sreg <= (sreg >> 1) | (DATA_W'(q_in) << (DATA_W - 1));
      end
      if (state == PARITY) begin
        par_bit <= q_in;
      end
    end
  end

  // Output holding register with valid/ready handshake and overrun detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        if (!data_valid || data_ready) begin
          data_out   <= sreg;
          data_valid <= 1'b1;
          parity_err <= perr_calc;
          frame_err  <= q_in;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed self-checking bench for serial_frame_deserializer: default
// configuration (DATA_W=8, parity on) plus a DATA_W=4 no-parity instance.
module tb_serial_frame_deserializer;

  logic       clk;
  logic       rst_n;
  logic       q_in;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err, overrun, busy;

  logic       q_in4;
  logic       data_ready4;
  logic [3:0] data_out4;
  logic       data_valid4, parity_err4, frame_err4, overrun4, busy4;

  int checks = 0;
  int errors = 0;

  serial_frame_deserializer u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .q_in       (q_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  serial_frame_deserializer #(.DATA_W(4), .PARITY_EN(0)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .q_in       (q_in4),
    .data_out   (data_out4),
    .data_valid (data_valid4),
    .data_ready (data_ready4),
    .parity_err (parity_err4),
    .frame_err  (frame_err4),
    .overrun    (overrun4),
    .busy       (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: returns at the falling edge after the next rising edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    q_in = b;
    tick();
  endtask

  task automatic drive_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; q_in = 1'b0; data_ready = 1'b0; q_in4 = 1'b0; data_ready4 = 1'b0;
    tick(); tick();
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data_out); end
    checks++; if ({data_valid, parity_err, frame_err, overrun, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000", {data_valid, parity_err, frame_err, overrun, busy}); end
    checks++; if ({data_valid4, busy4, data_out4} !== 6'b0) begin
      errors++; $display("FAIL reset_dut4 got %b exp 000000", {data_valid4, busy4, data_out4}); end
    rst_n = 1'b1;
    tick();
  endtask

  // Busy covers the ten cycles after the start-bit edge up to the stop-bit edge
  task automatic test_basic();
    int busy_cnt;
    busy_cnt = 0;
    q_in = 1'b1; tick(); if (busy) busy_cnt++;
    for (int i = 0; i < 8; i++) begin
      q_in = (8'hA5 >> i) & 1'b1;
      tick(); if (busy) busy_cnt++;
    end
    q_in = 1'b0; tick(); if (busy) busy_cnt++;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", data_valid); end
    q_in = 1'b0; tick(); if (busy) busy_cnt++;
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", data_out); end
    checks++; if ({data_valid, parity_err, frame_err, overrun} !== 4'b1000) begin
      errors++; $display("FAIL basic_flags got %b exp 1000", {data_valid, parity_err, frame_err, overrun}); end
    checks++; if (busy_cnt != 10) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 10", busy_cnt); end
    data_ready = 1'b1; tick(); data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_accept got %b exp 0", data_valid); end
  endtask

  task automatic test_errors();
    drive_bit(1'b1); drive_byte(8'hA5); drive_bit(1'b1); drive_bit(1'b1);
    checks++; if ({data_valid, data_out} !== {1'b1, 8'hA5}) begin
      errors++; $display("FAIL err_data got %b/%h exp 1/a5", data_valid, data_out); end
    checks++; if ({parity_err, frame_err} !== 2'b11) begin
      errors++; $display("FAIL err_flags got %b exp 11", {parity_err, frame_err}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_stop_idle got %b exp 0", busy); end
    drive_bit(1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_no_restart got %b exp 0", busy); end
    data_ready = 1'b1; tick(); data_ready = 1'b0;
  endtask

  task automatic test_overrun();
    drive_bit(1'b1); drive_byte(8'h3C); drive_bit(1'b0); drive_bit(1'b0);
    checks++; if ({data_valid, data_out} !== {1'b1, 8'h3C}) begin
      errors++; $display("FAIL ovr_first got %b/%h exp 1/3c", data_valid, data_out); end
    drive_bit(1'b1); drive_byte(8'hC3); drive_bit(1'b0); drive_bit(1'b0);
    checks++; if ({data_valid, data_out, overrun} !== {1'b1, 8'h3C, 1'b1}) begin
      errors++; $display("FAIL ovr_pulse got %b/%h/%b exp 1/3c/1", data_valid, data_out, overrun); end
    drive_bit(1'b0);
    checks++; if ({overrun, data_out} !== {1'b0, 8'h3C}) begin
      errors++; $display("FAIL ovr_one_cycle got %b/%h exp 0/3c", overrun, data_out); end
    data_ready = 1'b1; tick(); data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept got %b exp 0", data_valid); end
  endtask

  task automatic test_back_to_back();
    drive_bit(1'b1); drive_byte(8'h3C); drive_bit(1'b0); drive_bit(1'b0);
    drive_bit(1'b1); drive_byte(8'hC3); drive_bit(1'b0);
    data_ready = 1'b1; q_in = 1'b0; tick();
    checks++; if ({data_valid, data_out, overrun} !== {1'b1, 8'hC3, 1'b0}) begin
      errors++; $display("FAIL b2b_swap got %b/%h/%b exp 1/c3/0", data_valid, data_out, overrun); end
    tick(); data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL b2b_accept got %b exp 0", data_valid); end
    data_ready = 1'b1; tick(); data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL ready_ignored got %b exp 0", data_valid); end
  endtask

  task automatic test_reset_mid();
    drive_bit(1'b1); drive_byte(8'h5A); drive_bit(1'b0); drive_bit(1'b0);
    drive_bit(1'b1);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rst_n = 1'b0; #1;
    checks++; if ({data_valid, data_out, parity_err, frame_err, overrun, busy} !== 13'b0) begin
      errors++; $display("FAIL rst_mid got %b/%h/%b exp 0/00/0000", data_valid, data_out,
                         {parity_err, frame_err, overrun, busy}); end
    @(negedge clk); q_in = 1'b0; rst_n = 1'b1; tick();
    checks++; if ({data_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL rst_release got %b exp 00", {data_valid, busy}); end
    drive_bit(1'b1); drive_byte(8'h12); drive_bit(1'b0); drive_bit(1'b0);
    checks++; if ({data_valid, data_out, parity_err, frame_err} !== {1'b1, 8'h12, 2'b00}) begin
      errors++; $display("FAIL rst_clean got %b/%h/%b exp 1/12/00", data_valid, data_out, {parity_err, frame_err}); end
    data_ready = 1'b1; tick(); data_ready = 1'b0;
  endtask

  task automatic test_w4_noparity();
    logic [3:0] d;
    d = 4'hD;
    q_in4 = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin q_in4 = d[i]; tick(); end
    checks++; if (data_valid4 !== 1'b0) begin errors++; $display("FAIL w4_early got %b exp 0", data_valid4); end
    q_in4 = 1'b0; tick();
    checks++; if ({data_valid4, data_out4, parity_err4, frame_err4} !== {1'b1, 4'hD, 2'b00}) begin
      errors++; $display("FAIL w4_frame got %b/%h/%b exp 1/d/00", data_valid4, data_out4, {parity_err4, frame_err4}); end
    data_ready4 = 1'b1; tick(); data_ready4 = 1'b0;
    d = 4'h6;
    q_in4 = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin q_in4 = d[i]; tick(); end
    q_in4 = 1'b1; tick(); q_in4 = 1'b0;
    checks++; if ({data_valid4, data_out4, parity_err4, frame_err4} !== {1'b1, 4'h6, 2'b01}) begin
      errors++; $display("FAIL w4_stop_err got %b/%h/%b exp 1/6/01", data_valid4, data_out4, {parity_err4, frame_err4}); end
    tick();
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL w4_idle got %b exp 0", busy4); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_w4_noparity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
